wb_arbiter: RTL
===============

# wb_arbiter

Two-master, one-slave pipelined Wishbone arbiter that lets the core's instruction and data adapters share a single memory/peripheral bus. Master 0 is the instruction port and master 1 is the data port. The grant is held for a master's entire `cyc` period, and outstanding pipelined requests are counted so the slave is never over-issued. It sits between the core's bus adapters and the single-port system interconnect.

## Interface
Parameters:
- `ADDR_W`, 32, address width.
- `DATA_W`, 32, data width; `SEL_W = DATA_W/8`.
- `MAX_OUTST`, 4, maximum accepted-but-unacked requests per grant (≥1).
- `CNT_W`, `$clog2(MAX_OUTST+1)`, outstanding counter width (derived).

Ports (N = 0, 1):
- `clk_i` input 1: the single clock; all state on the rising edge.
- `rst_i` input 1: reset, synchronous and active-high.
- `mN_cyc_i` input 1: master N cycle request.
- `mN_stb_i` input 1: master N strobe.
- `mN_we_i` input 1: master N write enable.
- `mN_adr_i` input ADDR_W: master N address.
- `mN_sel_i` input SEL_W: master N byte select.
- `mN_dat_i` input DATA_W: master N write data.
- `mN_dat_o` output DATA_W: read data, always equal to `s_dat_i`.
- `mN_ack_o` output 1: ack routed to the granted master only.
- `mN_stall_o` output 1: stall to master N.
- `s_cyc_o`, `s_stb_o`, `s_we_o` output 1: slave-side controls.
- `s_adr_o` output ADDR_W, `s_sel_o` output SEL_W, `s_dat_o` output DATA_W: slave-side request fields.
- `s_dat_i` input DATA_W, `s_ack_i` input 1, `s_stall_i` input 1: slave responses.
- `grant_o` output 2: one-hot current grant, `2'b00` when idle.

## Operation
State machine: `IDLE`, `GNT0`, `GNT1`.

IDLE:
- All `s_*` outputs are 0.
- Both `mN_stall_o` are 1 and both `mN_ack_o` are 0.
- At a clock edge with exactly one `mN_cyc_i`=1, go to `GNTN`.
- With both `mN_cyc_i`=1, arbitrate per the priority rule in Configuration.

GNTN:
- `s_cyc_o = mN_cyc_i`.
- `s_stb_o = mN_stb_i && (cnt != MAX_OUTST)`.
- `s_we_o`, `s_adr_o`, `s_sel_o` and `s_dat_o` are copied from master N.
- `mN_stall_o = s_stall_i || (cnt == MAX_OUTST)`.
- `mN_ack_o = s_ack_i && (cnt != 0)`.
- The non-granted master sees stall=1 and ack=0.

Outstanding counter `cnt`:
- +1 on `s_stb_o && !s_stall_i`.
- −1 on a forwarded ack.
- Unchanged when both happen in the same cycle.
- Never exceeds `MAX_OUTST`.
- An ack with `cnt==0` is stray: it is dropped and `cnt` stays 0.

Release:
- At an edge in `GNTN` with `mN_cyc_i`=0, `cnt` is cleared.
- The next state is `GNT(other)` if the other master's `cyc_i`=1, else `IDLE`.
- Handoff is direct, with no idle bubble.
- A master that drops `cyc` with `cnt != 0` has terminated its cycle. Late acks arriving after release are not forwarded to the new master, because `cnt` restarts at 0.

## Timing
- Reset values: state `IDLE`, `cnt`=0, round-robin pointer = last grant 0, `grant_o`=0, all `s_*` outputs 0, `mN_stall_o`=1, `mN_ack_o`=0.
- Arbitration latency: a request first seen in `IDLE` at edge k reaches the slave in cycle k+1. Master stall is 1 during cycle k.
- Request forwarding and ack routing are combinational within a grant: zero added latency, with full pipelined throughput of one request per cycle up to `MAX_OUTST`.
- `rst_i` asserted mid-transfer: state returns to reset values at the next edge regardless of `cyc`, `stb` or `ack`.
- `mN_dat_o` passes through combinationally at all times.

## Configuration
- `WB_ARBITER_RR_EN` defined: round-robin. On a simultaneous request in `IDLE`, the master not granted most recently wins; the pointer updates on every grant.
- Not defined: fixed priority, with master 1 (data) always winning ties; no pointer register.
- Grant hold and release behaviour are identical in both modes.

## Structure
- Shared package `wb_pkg` holds:
  - typedef `wb_arb_state_t` (`IDLE`, `GNT0`, `GNT1`);
  - the `WB_ARB_NMASTERS = 2` constant.
- No sub-module: the counter, FSM and output muxes are a single flat module.

## Test plan
- Single master: m0 issues 3 pipelined reads at 0x100/0x104/0x108; slave acks 2 cycles later each. Expect `grant_o`=01 one cycle after `cyc`, three acks on m0 only, `cnt` back to 0.
- Simultaneous request in `IDLE`, both `cyc` rising together. Fixed mode: m1 granted. RR mode: m1 granted after reset, then m0 on the next tie.
- Outstanding limit: `MAX_OUTST`=4, slave never acks. After 4 accepted strobes, `s_stb_o`=0 and `m0_stall_o`=1; one ack re-enables exactly one more strobe.
- Handoff: m1 holds `cyc` while m0 requests; m1 drops `cyc` at edge k. Expect `grant_o`=01 from cycle k+1 with no idle cycle.
- Stray ack: `s_ack_i`=1 in `IDLE` and in `GNT0` with `cnt`=0. Expect no `mN_ack_o` and `cnt` stays 0.
- Reset mid-burst: assert `rst_i` with `cnt`=2. Next cycle: `s_cyc_o`=0, `grant_o`=0, both stalls 1.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared Wishbone arbiter definitions.
//   wb_arb_state_t  : arbiter FSM states (IDLE, GNT0, GNT1)
//   WB_ARB_NMASTERS : number of masters sharing the slave port
package wb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } wb_arb_state_t;

  localparam int WB_ARB_NMASTERS = 2;

endpackage

// File: rtl/wb_arbiter.sv
// Two-master, one-slave pipelined Wishbone arbiter.
// Master 0 is the instruction port, master 1 the data port. A grant is held
// for the whole cyc period of the granted master; accepted-but-unacked
// requests are counted so no more than MAX_OUTST are ever in flight.
//
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   mN_cyc_i/stb_i/we_i/adr_i/sel_i/dat_i   master N request (N = 0, 1)
//   mN_dat_o                         read data (always s_dat_i)
//   mN_ack_o, mN_stall_o             ack / stall back to master N
//   s_cyc_o/stb_o/we_o/adr_o/sel_o/dat_o    slave request
//   s_dat_i, s_ack_i, s_stall_i      slave response
//   grant_o                          one-hot grant, 2'b00 when idle
//
// Configuration macro:
//   WB_ARBITER_RR_EN  defined   : round-robin tie break in IDLE
//                     undefined : fixed priority, master 1 wins ties
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SEL_W     = DATA_W / 8,
  parameter int MAX_OUTST = 4,
  parameter int CNT_W     = $clog2(MAX_OUTST + 1)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,

  input  logic                       m0_cyc_i,
  input  logic                       m0_stb_i,
  input  logic                       m0_we_i,
  input  logic [ADDR_W-1:0]          m0_adr_i,
  input  logic [SEL_W-1:0]           m0_sel_i,
  input  logic [DATA_W-1:0]          m0_dat_i,
  output logic [DATA_W-1:0]          m0_dat_o,
  output logic                       m0_ack_o,
  output logic                       m0_stall_o,

  input  logic                       m1_cyc_i,
  input  logic                       m1_stb_i,
  input  logic                       m1_we_i,
  input  logic [ADDR_W-1:0]          m1_adr_i,
  input  logic [SEL_W-1:0]           m1_sel_i,
  input  logic [DATA_W-1:0]          m1_dat_i,
  output logic [DATA_W-1:0]          m1_dat_o,
  output logic                       m1_ack_o,
  output logic                       m1_stall_o,

  output logic                       s_cyc_o,
  output logic                       s_stb_o,
  output logic                       s_we_o,
  output logic [ADDR_W-1:0]          s_adr_o,
  output logic [SEL_W-1:0]           s_sel_o,
  output logic [DATA_W-1:0]          s_dat_o,
  input  logic [DATA_W-1:0]          s_dat_i,
  input  logic                       s_ack_i,
  input  logic                       s_stall_i,

  output logic [WB_ARB_NMASTERS-1:0] grant_o
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTST);

  wb_arb_state_t    state;
  logic [CNT_W-1:0] cnt;

  logic          full;
  logic          fwd_ack;
  logic          accept;
  wb_arb_state_t tie_state;

  assign full    = (cnt == CNT_MAX);
  // An ack with nothing outstanding is stray and never reaches a master.
  assign fwd_ack = s_ack_i && (cnt != '0) && (state != IDLE);
  assign accept  = s_stb_o && !s_stall_i;

`ifdef WB_ARBITER_RR_EN
  // Last master granted; 0 after reset so master 1 wins the first tie.
  logic last_gnt;

  // Tracking the state one cycle late is enough: ties are only resolved in
  // IDLE, which is always at least one cycle after the previous grant.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      last_gnt <= 1'b0;
    end else if (state == GNT0) begin
      last_gnt <= 1'b0;
    end else if (state == GNT1) begin
      last_gnt <= 1'b1;
    end
  end

  assign tie_state = last_gnt ? GNT0 : GNT1;
`else
  assign tie_state = GNT1;
`endif

  // Grant FSM and outstanding-request counter
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (m0_cyc_i && m1_cyc_i) begin
            state <= tie_state;
          end else if (m0_cyc_i) begin
            state <= GNT0;
          end else if (m1_cyc_i) begin
            state <= GNT1;
          end
        end
        GNT0: begin
          if (!m0_cyc_i) begin
            // Cycle terminated: any late acks are orphaned by the clear.
            cnt   <= '0;
            state <= m1_cyc_i ? GNT1 : IDLE;
          end else if (accept && !fwd_ack) begin
            cnt <= cnt + CNT_W'(1);
          end else if (!accept && fwd_ack) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        GNT1: begin
          if (!m1_cyc_i) begin
            cnt   <= '0;
            state <= m0_cyc_i ? GNT0 : IDLE;
          end else if (accept && !fwd_ack) begin
            cnt <= cnt + CNT_W'(1);
          end else if (!accept && fwd_ack) begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Combinational request forwarding and response routing
  always_comb begin
    s_cyc_o    = 1'b0;
    s_stb_o    = 1'b0;
    s_we_o     = 1'b0;
    s_adr_o    = '0;
    s_sel_o    = '0;
    s_dat_o    = '0;
    m0_ack_o   = 1'b0;
    m1_ack_o   = 1'b0;
    m0_stall_o = 1'b1;
    m1_stall_o = 1'b1;
    grant_o    = '0;
    unique case (state)
      GNT0: begin
        grant_o    = 2'b01;
        s_cyc_o    = m0_cyc_i;
        s_stb_o    = m0_stb_i && !full;
        s_we_o     = m0_we_i;
        s_adr_o    = m0_adr_i;
        s_sel_o    = m0_sel_i;
        s_dat_o    = m0_dat_i;
        m0_stall_o = s_stall_i || full;
        m0_ack_o   = fwd_ack;
      end
      GNT1: begin
        grant_o    = 2'b10;
        s_cyc_o    = m1_cyc_i;
        s_stb_o    = m1_stb_i && !full;
        s_we_o     = m1_we_i;
        s_adr_o    = m1_adr_i;
        s_sel_o    = m1_sel_i;
        s_dat_o    = m1_dat_i;
        m1_stall_o = s_stall_i || full;
        m1_ack_o   = fwd_ack;
      end
      default: begin
      end
    endcase
  end

  assign m0_dat_o = s_dat_i;
  assign m1_dat_o = s_dat_i;

endmodule
